// File: rtl/dlx_dmem_ctrl.sv
// DLX data-memory controller: turns byte/half/word loads and stores into whole-word
// memory transactions, with read-modify-write for sub-word stores and load extension.
module dlx_dmem_ctrl #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [1:0]              cpu_size,
    input  logic                    cpu_signed,
    input  logic [31:0]             cpu_addr,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic [WORD_SIZE-1:0]    cpu_rdata,
    output logic                    cpu_stall,
    output logic                    cpu_done,
    output logic                    cpu_err,
    output logic                    ENABLE,
    output logic                    READNOTWRITE,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [WORD_SIZE-1:0]    DATA_OUT,
    input  logic [WORD_SIZE-1:0]    DATA_IN,
    input  logic                    DATA_READY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

    state_t                  state, state_next;
    logic [ADDRESS_SIZE+1:0] addr_q;
    logic [1:0]              size_q;
    logic                    signed_q;
    logic [WORD_SIZE-1:0]    wdata_q;
    logic [WORD_SIZE-1:0]    rdata_q;
    logic [WORD_SIZE-1:0]    dout_q;
    logic                    err_q;
    logic [CNT_W-1:0]        cnt;

    logic                    misaligned;
    logic                    in_access;
    logic                    ready_ok;
    logic                    timed_out;
    logic [WORD_SIZE-1:0]    lane_mask;
    logic [WORD_SIZE-1:0]    lane_data;
    logic [WORD_SIZE-1:0]    load_data;
    logic [WORD_SIZE-1:0]    merged;
    logic                    lane_sign;
    int                      lane_shift;
    logic                    addr_unused;

    assign addr_unused = ^cpu_addr[31:ADDRESS_SIZE+2];

    assign misaligned = (cpu_size == 2'b01 && cpu_addr[0]) ||
                        (cpu_size[1] && cpu_addr[1:0] != 2'b00);

    // Big-endian lanes: the lowest byte offset lives in the most significant bits.
    always_comb begin
        lane_mask  = '1;
        lane_shift = 0;
        if (size_q == 2'b00) begin
            lane_mask  = WORD_SIZE'(8'hFF);
            lane_shift = WORD_SIZE - 8 - 8 * int'(addr_q[1:0]);
        end else if (size_q == 2'b01) begin
            lane_mask  = WORD_SIZE'(16'hFFFF);
            lane_shift = WORD_SIZE - 16 - 8 * int'(addr_q[1:0]);
        end
        lane_data = (DATA_IN >> lane_shift) & lane_mask;
        lane_sign = (size_q == 2'b00) ? lane_data[7] : lane_data[15];
        load_data = lane_data;
        if (signed_q && !size_q[1] && lane_sign)
            load_data = lane_data | ~lane_mask;
        merged = (DATA_IN & ~(lane_mask << lane_shift)) |
                 ((wdata_q & lane_mask) << lane_shift);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (in_access)
                cnt <= cnt + 1'b1;
        end
    end

    // DATA_READY is sticky in memory, so the first cycle of an access state is never
    // trusted; RMW_WR skips one more because its first cycle is the ENABLE-low gap.
    always_comb begin
        in_access  = (state == RD) || (state == RMW_RD) || (state == WR) || (state == RMW_WR);
        timed_out  = (cnt == CNT_W'(TIMEOUT - 1));
        ready_ok   = DATA_READY && ((state == RMW_WR) ? (cnt > CNT_W'(1)) : (cnt != '0));
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (misaligned)   state_next = DONE;
                    else if (!cpu_we) state_next = RD;
                    else if (cpu_size[1]) state_next = WR;
                    else              state_next = RMW_RD;
                end
            end
            RD, WR, RMW_WR: begin
                if (ready_ok || timed_out) state_next = DONE;
            end
            RMW_RD: begin
                if (ready_ok)       state_next = RMW_WR;
                else if (timed_out) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_q   <= cpu_addr[ADDRESS_SIZE+1:0];
                size_q   <= cpu_size;
                signed_q <= cpu_signed;
                wdata_q  <= cpu_wdata;
                err_q    <= misaligned;
                if (misaligned)
                    rdata_q <= '0;
                else if (cpu_we && cpu_size[1])
                    dout_q <= cpu_wdata;
            end
            if (state == RD && ready_ok)
                rdata_q <= load_data;
            if (state == RMW_RD && ready_ok)
                dout_q <= merged;
            if (in_access && !ready_ok && timed_out)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        ENABLE       = in_access && !(state == RMW_WR && cnt == '0);
        READNOTWRITE = !((state == WR) || (state == RMW_WR));
        ADDRESS      = addr_q[ADDRESS_SIZE+1:2];
        DATA_OUT     = dout_q;
        cpu_rdata    = rdata_q;
        cpu_done     = (state == DONE);
        cpu_err      = (state == DONE) && err_q;
        cpu_stall    = (state == IDLE && cpu_req) || (state != IDLE && state != DONE);
    end

endmodule

// File: tb/tb_dlx_dmem_ctrl.sv
// Table-driven bench for dlx_dmem_ctrl with a word-addressed memory model whose
// DATA_READY is sticky and answers a programmable number of cycles after ENABLE.
module tb_dlx_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;
    logic        ENABLE;
    logic        READNOTWRITE;
    logic [15:0] ADDRESS;
    logic [31:0] DATA_OUT;
    logic [31:0] DATA_IN;
    logic        DATA_READY;

    dlx_dmem_ctrl #(.WORD_SIZE(32), .ADDRESS_SIZE(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
        .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .ENABLE(ENABLE), .READNOTWRITE(READNOTWRITE), .ADDRESS(ADDRESS),
        .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN), .DATA_READY(DATA_READY)
    );

    always #5 clk = ~clk;

    // Memory model: a preload port plus the sticky-ready handshake.
    logic [31:0] mem [0:63];
    int          lat = 1;
    bit          mem_dead = 1'b0;
    int          wcnt = 0;
    bit          pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (!ENABLE) begin
            DATA_READY <= 1'b0;
            wcnt       <= 0;
        end else if (!DATA_READY && !mem_dead) begin
            if (wcnt >= lat - 1) begin
                DATA_READY <= 1'b1;
                if (READNOTWRITE) DATA_IN <= mem[ADDRESS[5:0]];
                else              mem[ADDRESS[5:0]] <= DATA_OUT;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          dead;
        logic [31:0] pre;
        logic [15:0] exp_addr;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_mem;
        int          exp_lat;
        int          exp_en;
        int          exp_rises;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   compares = 0;
    int   miscompares = 0;

    function automatic vec_t mkVec(string name, logic we, logic [1:0] size, logic sgn,
                                   logic [31:0] addr, logic [31:0] wdata, int l, bit dead,
                                   logic [31:0] pre, logic [15:0] exp_addr, bit chk_rd,
                                   logic [31:0] exp_rd, logic exp_err, logic [31:0] exp_mem,
                                   int exp_lat, int exp_en, int exp_rises);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.lat = l; v.dead = dead; v.pre = pre; v.exp_addr = exp_addr;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_mem = exp_mem;
        v.exp_lat = exp_lat; v.exp_en = exp_en; v.exp_rises = exp_rises;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // One full transaction: request at cycle 0, observe every cycle until cpu_done.
    task automatic applyStimulus(input vec_t v);
        int          cyc = 0;
        int          done_at = -1;
        int          en_cyc = 0;
        int          rises = 0;
        int          addr_bad = 0;
        int          stall_bad = 0;
        logic        prev_en = 1'b0;
        logic [31:0] rd = '0;
        logic        er = 1'b0;
        logic [31:0] a;
        logic [5:0]  idx;
        a   = v.addr;
        idx = a[7:2];
        vectors++;
        preload(idx, v.pre);
        lat      = v.lat;
        mem_dead = v.dead;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = v.we; cpu_size = v.size; cpu_signed = v.sgn;
        cpu_addr = v.addr; cpu_wdata = v.wdata;
        #1;
        if (!cpu_stall) stall_bad++;
        while (done_at < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ENABLE) begin
                en_cyc++;
                if (!prev_en) rises++;
                if (ADDRESS !== v.exp_addr) addr_bad++;
            end
            prev_en = ENABLE;
            if (cpu_done) begin
                done_at = cyc;
                rd      = cpu_rdata;
                er      = cpu_err;
                if (cpu_stall) stall_bad++;
                cpu_req = 1'b0;
            end else if (!cpu_stall) begin
                stall_bad++;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checkOutput({v.name, " latency"}, done_at, v.exp_lat);
        checkOutput({v.name, " cpu_err"}, {31'b0, er}, {31'b0, v.exp_err});
        if (v.chk_rd) checkOutput({v.name, " cpu_rdata"}, rd, v.exp_rd);
        checkOutput({v.name, " mem word"}, mem[idx], v.exp_mem);
        checkOutput({v.name, " enable cycles"}, en_cyc, v.exp_en);
        checkOutput({v.name, " enable bursts"}, rises, v.exp_rises);
        checkOutput({v.name, " address errors"}, addr_bad, 0);
        checkOutput({v.name, " stall errors"}, stall_bad, 0);
        checkOutput({v.name, " idle after done"}, {29'b0, cpu_done, cpu_stall, ENABLE}, 0);
        mem_dead = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          cyc, first, second, quiet_done;
        logic [31:0] r1, r2;

        vecs.push_back(mkVec("ld_w_40",     0, 2'd2, 0, 32'h40, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_bs_41",    0, 2'd0, 1, 32'h41, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'hFFFFFFAD, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_bu_41",    0, 2'd0, 0, 32'h41, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'h000000AD, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_hs_42",    0, 2'd1, 1, 32'h42, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'hFFFFBEEF, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_hu_40_l2", 0, 2'd1, 0, 32'h40, 0, 2, 0, 32'hDEADBEEF, 16'h10, 1, 32'h0000DEAD, 0, 32'hDEADBEEF, 4, 3, 1));
        vecs.push_back(mkVec("ld_bs_43_l3", 0, 2'd0, 1, 32'h43, 0, 3, 0, 32'hDEADBEEF, 16'h10, 1, 32'hFFFFFFEF, 0, 32'hDEADBEEF, 5, 4, 1));
        vecs.push_back(mkVec("ld_bs_40",    0, 2'd0, 1, 32'h40, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'hFFFFFFDE, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_hs_40_pos",0, 2'd1, 1, 32'h40, 0, 1, 0, 32'h7FFF8000, 16'h10, 1, 32'h00007FFF, 0, 32'h7FFF8000, 3, 2, 1));
        vecs.push_back(mkVec("ld_hs_42_neg",0, 2'd1, 1, 32'h42, 0, 1, 0, 32'h7FFF8000, 16'h10, 1, 32'hFFFF8000, 0, 32'h7FFF8000, 3, 2, 1));
        vecs.push_back(mkVec("ld_s11_40",   0, 2'd3, 1, 32'h40, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3, 2, 1));
        vecs.push_back(mkVec("ld_w_far",    0, 2'd2, 0, 32'h00010084, 0, 1, 0, 32'h89ABCDEF, 16'h4021, 1, 32'h89ABCDEF, 0, 32'h89ABCDEF, 3, 2, 1));
        vecs.push_back(mkVec("st_b_43",     1, 2'd0, 0, 32'h43, 32'h1234565A, 1, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hDEADBE5A, 6, 4, 2));
        vecs.push_back(mkVec("st_h_40_l2",  1, 2'd1, 0, 32'h40, 32'hFFFFCAFE, 2, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hCAFEBEEF, 8, 6, 2));
        vecs.push_back(mkVec("st_b_42",     1, 2'd0, 0, 32'h42, 32'h00000077, 1, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hDEAD77EF, 6, 4, 2));
        vecs.push_back(mkVec("st_b_41",     1, 2'd0, 0, 32'h41, 32'hFFFFFF00, 1, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hDE00BEEF, 6, 4, 2));
        vecs.push_back(mkVec("st_h_42",     1, 2'd1, 0, 32'h42, 32'hABCD1234, 1, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hDEAD1234, 6, 4, 2));
        vecs.push_back(mkVec("st_w_40",     1, 2'd2, 0, 32'h40, 32'h01234567, 1, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'h01234567, 3, 2, 1));
        vecs.push_back(mkVec("st_s11_40_l3",1, 2'd3, 0, 32'h40, 32'hA5A5A5A5, 3, 0, 32'hDEADBEEF, 16'h10, 0, 0, 0, 32'hA5A5A5A5, 5, 4, 1));
        vecs.push_back(mkVec("mis_w_ld_42", 0, 2'd2, 0, 32'h42, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mkVec("ld_w_40_b",   0, 2'd2, 0, 32'h40, 0, 1, 0, 32'h13572468, 16'h10, 1, 32'h13572468, 0, 32'h13572468, 3, 2, 1));
        vecs.push_back(mkVec("mis_h_st_41", 1, 2'd1, 0, 32'h41, 32'h1111, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mkVec("mis_w_st_41", 1, 2'd2, 0, 32'h41, 32'h2222, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mkVec("mis_h_ld_43", 0, 2'd1, 1, 32'h43, 0, 1, 0, 32'hDEADBEEF, 16'h10, 1, 32'h0, 1, 32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mkVec("tmo_ld_w",    0, 2'd2, 0, 32'h40, 0, 1, 1, 32'hDEADBEEF, 16'h10, 0, 0, 1, 32'hDEADBEEF, 9, 8, 1));
        vecs.push_back(mkVec("tmo_st_b",    1, 2'd0, 0, 32'h43, 32'h5A, 1, 1, 32'hDEADBEEF, 16'h10, 0, 0, 1, 32'hDEADBEEF, 9, 8, 1));

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        vectors++;
        checkOutput("reset ENABLE", {31'b0, ENABLE}, 0);
        checkOutput("reset READNOTWRITE", {31'b0, READNOTWRITE}, 1);
        checkOutput("reset ADDRESS", {16'b0, ADDRESS}, 0);
        checkOutput("reset outputs", {cpu_done, cpu_err, cpu_stall}, 0);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Back-to-back: request held high across DONE is taken in the following IDLE.
        vectors++;
        preload(6'h10, 32'hDEADBEEF);
        preload(6'h11, 32'h0BADF00D);
        lat = 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_signed = 1'b0; cpu_addr = 32'h40;
        cyc = 0; first = -1; second = -1; r1 = '0; r2 = '0;
        while (second < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cpu_done) begin
                if (first < 0) begin
                    first = cyc; r1 = cpu_rdata; cpu_addr = 32'h44;
                end else begin
                    second = cyc; r2 = cpu_rdata; cpu_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        checkOutput("b2b first done", first, 3);
        checkOutput("b2b second done", second, 7);
        checkOutput("b2b first rdata", r1, 32'hDEADBEEF);
        checkOutput("b2b second rdata", r2, 32'h0BADF00D);

        // Reset in the middle of RMW_RD: everything returns to reset values, no write.
        applyStimulus(vecs[0]);
        vectors++;
        preload(6'h10, 32'hDEADBEEF);
        lat = 3;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h43; cpu_wdata = 32'h5A;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rmw_rd reached", {30'b0, ENABLE, READNOTWRITE}, 32'h3);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("mid-rst ENABLE/RNW", {30'b0, ENABLE, READNOTWRITE}, 32'h1);
        checkOutput("mid-rst ADDRESS", {16'b0, ADDRESS}, 0);
        checkOutput("mid-rst DATA_OUT", DATA_OUT, 0);
        checkOutput("mid-rst cpu_rdata", cpu_rdata, 0);
        checkOutput("mid-rst flags", {cpu_done, cpu_err, cpu_stall}, 0);
        rst = 1'b0;
        quiet_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_done || ENABLE) quiet_done++;
        end
        checkOutput("mid-rst no activity", quiet_done, 0);
        checkOutput("mid-rst mem unchanged", mem[16], 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dlx_dmem_ctrl.md
Name: dlx_dmem_ctrl

Overview:
Data-memory controller between the DLX MEM stage and the word-addressed read/write data memory model on the memory interface. Converts CPU byte-addressed loads/stores of byte/half/word size into whole-word memory transactions. Performs read-modify-write for sub-word stores and sign/zero extension for loads. Stalls the pipeline until the access completes and flags misaligned or timed-out accesses.

Parameters:
WORD_SIZE, 32, data width of CPU and memory words
ADDRESS_SIZE, 16, memory word-address width
TIMEOUT, 64, max cycles waiting for DATA_READY before error

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  access request, held by CPU while cpu_stall=1
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
cpu_signed  in  1  load sign-extends when 1
cpu_addr  in  32  byte address
cpu_wdata  in  WORD_SIZE  store data, right-aligned
cpu_rdata  out  WORD_SIZE  extended load data, valid with cpu_done
cpu_stall  out  1  pipeline freeze
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle error pulse, coincident with cpu_done
ENABLE  out  1  memory access enable
READNOTWRITE  out  1  1=read, 0=write
ADDRESS  out  ADDRESS_SIZE  word address = cpu_addr[ADDRESS_SIZE+1:2]
DATA_OUT  out  WORD_SIZE  write data, driven onto memory data bus when READNOTWRITE=0
DATA_IN  in  WORD_SIZE  read data from memory bus
DATA_READY  in  1  memory completion

Behaviour:
- Reset (rst=1 at posedge): state IDLE; ENABLE=0, READNOTWRITE=1, ADDRESS=0, DATA_OUT=0, cpu_rdata=0, cpu_done=0, cpu_err=0, timeout counter=0. Reset mid-transaction aborts with no done pulse; a partial RMW write is not issued.
- Byte lanes big-endian: offset 0 -> bits[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; half offset 0 -> [31:16], 2 -> [15:0].
- Alignment: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned -> no memory access; DONE next cycle with cpu_err=1, cpu_rdata=0.
- States: IDLE, RD (load read), RMW_RD (sub-word store read), RMW_WR (merged write), WR (word store), DONE.
- IDLE: on cpu_req, latch addr/size/signed/wdata. Next state: load -> RD; word store -> WR; byte/half store -> RMW_RD; misaligned -> DONE (err).
- RD/RMW_RD: ENABLE=1, READNOTWRITE=1. WR/RMW_WR: ENABLE=1, READNOTWRITE=0, DATA_OUT=merged/latched word.
- Completion: DATA_READY is sticky in the memory model, so it counts only when sampled high at a posedge at least one cycle after entering the access state (first cycle in state is ignored).
- RMW_RD complete -> latch DATA_IN, replace addressed lane(s) with low bits of cpu_wdata -> RMW_WR. ENABLE drops for exactly one cycle between RMW_RD and RMW_WR.
- RD complete: cpu_rdata <= extracted lane, sign-extended if cpu_signed else zero-extended; word passes unchanged -> DONE.
- WR/RMW_WR complete -> DONE.
- DONE: cpu_done=1 for one cycle; ENABLE=0; cpu_rdata holds until next load completes -> IDLE.
- cpu_stall = (state==IDLE & cpu_req) | (state not in {IDLE, DONE}). It is low in the DONE cycle.
- Timeout: counter increments each cycle in an access state and clears on state change. Reaching TIMEOUT -> DONE with cpu_err=1; ENABLE deasserts.
- Latency (memory answering in L cycles after ENABLE): load/word store = L+2 cycles request-to-done; sub-word store = 2L+4.
- cpu_req sampled only in IDLE; back-to-back requests are accepted in the cycle after DONE.

Test Plan:
- Word load: mem[0x10]=0xDEADBEEF, cpu_addr=0x40, size=10 -> ENABLE high, ADDRESS=0x10, cpu_rdata=0xDEADBEEF, single cpu_done pulse, cpu_err=0.
- Byte loads at 0x41: signed -> 0xFFFFFFAD; unsigned -> 0x000000AD. Half load at 0x42 signed -> 0xFFFFBEEF.
- Byte store 0x5A to 0x43 with mem[0x10]=0xDEADBEEF -> read then write sequence; mem[0x10]=0xDEADBE5A; stall high throughout; ENABLE low one cycle between phases.
- Misaligned word load at 0x42 -> no ENABLE, cpu_done=cpu_err=1 one cycle after request.
- DATA_READY forced low with TIMEOUT=8 -> cpu_err pulse after 8 access cycles, ENABLE returns low, FSM back in IDLE.
- rst asserted during RMW_RD -> outputs return to reset values next cycle; memory word unchanged; no cpu_done.
